// File: rtl/conv_pkg.sv
// conv_pkg: constants and types shared by the rate-1/2, K=3 convolutional
// encoder and the 14-bit-frame Viterbi decoder at the far end of the link.
//   MSG_BITS_DEF  payload bits per frame
//   TAIL_BITS     zero tail bits that flush the trellis back to state 00
//   INFO_LEN      info bits per frame (payload + tail)
//   FRAME_LEN     coded bits per frame (two per info bit)
//   G0_DEF/G1_DEF generator taps, bit order {u, s1, s0}
package conv_pkg;

  localparam int MSG_BITS_DEF = 5;
  localparam int TAIL_BITS    = 2;
  localparam int INFO_LEN     = MSG_BITS_DEF + TAIL_BITS;
  localparam int FRAME_LEN    = 2 * INFO_LEN;

  localparam logic [2:0] G0_DEF = 3'b111;
  localparam logic [2:0] G1_DEF = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } conv_state_e;

endpackage

// File: rtl/conv_branch.sv
// conv_branch: one trellis branch of the K=3 code, purely combinational.
//   u_i    info bit entering the encoder
//   st_i   trellis state {s1, s0}; s1 = previous info bit, s0 = the one before
//   code_o {c1, c0}; c0 is transmitted first
module conv_branch
  import conv_pkg::*;
#(
  parameter logic [2:0] G0 = G0_DEF,
  parameter logic [2:0] G1 = G1_DEF
) (
  input  logic       u_i,
  input  logic [1:0] st_i,
  output logic [1:0] code_o
);

  logic [2:0] reg_bits;

  assign reg_bits = {u_i, st_i};
  assign code_o   = {^(G1 & reg_bits), ^(G0 & reg_bits)};

endmodule

// File: rtl/conv_encoder.sv
// conv_encoder: rate-1/2, constraint-length-3 convolutional encoder.
// Takes MSG_BITS-bit messages over valid/ready, appends TAIL_BITS zeros and
// streams 2*(MSG_BITS+TAIL_BITS) coded bits, one per clk, MSB of the message
// first. Frames run back-to-back; at a frame boundary with no message the
// encoder either sends an all-zero filler frame (CONTINUOUS=1) or goes idle.
//   clk          system clock
//   reset        asynchronous, active-low reset
//   data_in      message, data_in[MSG_BITS-1] sent first
//   data_valid   data_in holds a message
//   data_ready   message is taken on this edge if data_valid
//   codebit      serial coded bit (registered)
//   code_valid   codebit belongs to a frame
//   frame_start  first coded bit of a frame
//   underflow    first coded bit of a filler frame
module conv_encoder
  import conv_pkg::*;
#(
  parameter int         MSG_BITS   = MSG_BITS_DEF,
  parameter logic [2:0] G0         = G0_DEF,
  parameter logic [2:0] G1         = G1_DEF,
  parameter bit         CONTINUOUS = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [MSG_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  output logic                codebit,
  output logic                code_valid,
  output logic                frame_start,
  output logic                underflow
);

  localparam int INFO  = MSG_BITS + TAIL_BITS;
  localparam int FRAME = 2 * INFO;
  localparam int CW    = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  conv_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;     // index of the coded bit now on codebit
  logic [INFO-1:0] info_q, info_d; // MSB = info bit currently being coded
  logic [1:0]    st_q, st_d;       // trellis state {s1, s0}
  logic          cb_q, cb_d;
  logic          cv_q, cv_d;
  logic          fs_q, fs_d;
  logic          uf_q, uf_d;

  logic                boundary;
  logic                load;
  logic                filler;
  logic [MSG_BITS-1:0] load_msg;
  logic                nxt_odd;
  logic                br_u;
  logic [1:0]          br_st;
  logic [1:0]          br_code;

  // Ready only when idle or while the last bit of a frame is on the wire, so
  // a message is always taken exactly at a frame boundary.
  assign boundary   = (state_q == IDLE) || (cnt_q == LAST);
  assign data_ready = boundary;

  // A new frame starts on a boundary when a message is offered, or in RUN
  // with nothing offered if filler frames are enabled.
  assign filler   = CONTINUOUS && (state_q == RUN) && !data_valid;
  assign load     = boundary && (data_valid || filler);
  assign load_msg = data_valid ? data_in : '0;

  // Coded bit for the next cycle: on a load it is c0 of the message MSB from
  // state 00; otherwise bit cnt_q+1, which is a c1 when cnt_q is even.
  assign nxt_odd = !load && !cnt_q[0];
  assign br_u    = load ? load_msg[MSG_BITS-1] : info_q[INFO-1];
  assign br_st   = load ? 2'b00 : st_q;

  conv_branch #(
    .G0 (G0),
    .G1 (G1)
  ) u_branch (
    .u_i    (br_u),
    .st_i   (br_st),
    .code_o (br_code)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      info_q  <= '0;
      st_q    <= 2'b00;
      cb_q    <= 1'b0;
      cv_q    <= 1'b0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      info_q  <= info_d;
      st_q    <= st_d;
      cb_q    <= cb_d;
      cv_q    <= cv_d;
      fs_q    <= fs_d;
      uf_q    <= uf_d;
    end
  end

  // Next-state: FSM plus the bit counter, message shifter and trellis state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    info_d  = info_q;
    st_d    = st_q;
    case (state_q)
      IDLE: if (data_valid) state_d = RUN;
      RUN:  if (boundary && !load) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load) begin
      cnt_d  = '0;
      info_d = {load_msg, {TAIL_BITS{1'b0}}};
      st_d   = 2'b00;
    end else if (state_q == RUN) begin
      if (boundary) begin
        cnt_d = '0;
        st_d  = 2'b00;
      end else begin
        cnt_d = cnt_q + 1'b1;
        // The trellis advances once both coded bits of an info bit are out.
        if (nxt_odd) begin
          st_d   = {info_q[INFO-1], st_q[1]};
          info_d = info_q << 1;
        end
      end
    end
  end

  // Output next values; everything leaves through a register.
  always_comb begin
    cv_d = (state_d == RUN);
    cb_d = cv_d && (nxt_odd ? br_code[1] : br_code[0]);
    fs_d = load;
    uf_d = load && !data_valid;
  end

  assign codebit     = cb_q;
  assign code_valid  = cv_q;
  assign frame_start = fs_q;
  assign underflow   = uf_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: one instance with CONTINUOUS=0 and one with
// CONTINUOUS=1. Stimulus pushes the expected frame when it offers a message;
// a monitor pops and compares every bit the DUT marks valid.
module tb_conv_encoder;
  import conv_pkg::*;

  typedef struct packed {
    logic cb;
    logic fs;
    logic uf;
  } exp_t;

  // Hand-computed frames for G0=111, G1=101.
  localparam logic [13:0] F_10000 = 14'b11101100000000;
  localparam logic [13:0] F_11111 = 14'b11011010100111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic [4:0] din [2];
  logic       vld [2];
  logic       rdy [2];
  logic       cb  [2];
  logic       cv  [2];
  logic       fs  [2];
  logic       uf  [2];

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad   = 0;

  conv_encoder #(.MSG_BITS(5), .G0(3'b111), .G1(3'b101), .CONTINUOUS(1'b0)) dut0 (
    .clk(clk), .reset(rst[0]), .data_in(din[0]), .data_valid(vld[0]),
    .data_ready(rdy[0]), .codebit(cb[0]), .code_valid(cv[0]),
    .frame_start(fs[0]), .underflow(uf[0])
  );

  conv_encoder #(.MSG_BITS(5), .G0(3'b111), .G1(3'b101), .CONTINUOUS(1'b1)) dut1 (
    .clk(clk), .reset(rst[1]), .data_in(din[1]), .data_valid(vld[1]),
    .data_ready(rdy[1]), .codebit(cb[1]), .code_valid(cv[1]),
    .frame_start(fs[1]), .underflow(uf[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference encoder written directly from the code equations.
  function automatic logic [13:0] enc(input logic [4:0] m);
    logic [6:0]  u;
    logic        s1, s0, uk;
    logic [13:0] r;
    u  = {m, 2'b00};
    s1 = 1'b0;
    s0 = 1'b0;
    r  = '0;
    for (int k = 0; k < 7; k++) begin
      uk          = u[6-k];
      r[13-2*k]   = uk ^ s1 ^ s0;
      r[12-2*k]   = uk ^ s0;
      s0          = s1;
      s1          = uk;
    end
    return r;
  endfunction

  task automatic push_frame(input int d, input logic [13:0] bits, input logic u);
    for (int i = 0; i < 14; i++) begin
      exp_t e;
      e.cb = bits[13-i];
      e.fs = (i == 0);
      e.uf = u && (i == 0);
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  // Called on a negedge where the DUT should be at a frame boundary; returns
  // on the negedge 14 cycles later (next boundary).
  task automatic boundary(input int d, input bit has, input logic [4:0] msg,
                          input logic [13:0] expb, input bit hold,
                          input logic [4:0] nxt);
    chk($sformatf("ready_at_boundary_dut%0d", d), rdy[d], 1);
    if (has) begin
      vld[d] = 1'b1;
      din[d] = msg;
      push_frame(d, expb, 1'b0);
    end else begin
      vld[d] = 1'b0;
      din[d] = 5'($urandom);
      push_frame(d, 14'd0, 1'b1);
    end
    @(posedge clk);
    #1;
    if (hold) begin
      vld[d] = 1'b1;
      din[d] = nxt;
    end else begin
      vld[d] = 1'b0;
      din[d] = 5'($urandom);
    end
    for (int i = 1; i <= 13; i++) begin
      @(negedge clk);
      chk($sformatf("ready_busy_dut%0d_bit%0d", d, i - 1), rdy[d], 0);
      if (i == 6 && !hold) din[d] = 5'($urandom);
    end
    @(negedge clk);
  endtask

  task automatic idle_check(input int d);
    @(negedge clk);
    chk($sformatf("idle_valid_dut%0d", d), cv[d], 0);
    chk($sformatf("idle_codebit_dut%0d", d), cb[d], 0);
    chk($sformatf("idle_ready_dut%0d", d), rdy[d], 1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d] && cv[d]) begin
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        if (d == 0 && q0.size() > 0) begin
          e = q0.pop_front();
          have = 1'b1;
        end else if (d == 1 && q1.size() > 0) begin
          e = q1.pop_front();
          have = 1'b1;
        end
        if (!have) chk($sformatf("unexpected_valid_dut%0d", d), 1, 0);
        else begin
          chk($sformatf("codebit_dut%0d", d), cb[d], e.cb);
          chk($sformatf("frame_start_dut%0d", d), fs[d], e.fs);
          chk($sformatf("underflow_dut%0d", d), uf[d], e.uf);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = '{1'b0, 1'b0};
    vld = '{1'b0, 1'b0};
    din = '{5'd0, 5'd0};
    #2;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset_valid_dut%0d", d), cv[d], 0);
      chk($sformatf("reset_codebit_dut%0d", d), cb[d], 0);
      chk($sformatf("reset_fs_dut%0d", d), fs[d], 0);
      chk($sformatf("reset_uf_dut%0d", d), uf[d], 0);
    end
    #10;
    rst = '{1'b1, 1'b1};
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("post_reset_ready_dut%0d", d), rdy[d], 1);
        chk($sformatf("post_reset_valid_dut%0d", d), cv[d], 0);
        chk($sformatf("post_reset_codebit_dut%0d", d), cb[d], 0);
      end
    end

    // CONTINUOUS=0: single frames drop back to idle, then a held back-to-back pair.
    boundary(0, 1'b1, 5'b10000, F_10000, 1'b0, 5'd0);
    idle_check(0);
    boundary(0, 1'b1, 5'b11111, F_11111, 1'b0, 5'd0);
    idle_check(0);
    boundary(0, 1'b1, 5'b10000, F_10000, 1'b1, 5'b11111);
    boundary(0, 1'b1, 5'b11111, F_11111, 1'b0, 5'd0);
    idle_check(0);
    idle_check(0);

    // CONTINUOUS=1: fillers between messages, then all 32 messages back-to-back.
    boundary(1, 1'b1, 5'b10000, F_10000, 1'b0, 5'd0);
    boundary(1, 1'b0, 5'd0, 14'd0, 1'b0, 5'd0);
    boundary(1, 1'b0, 5'd0, 14'd0, 1'b0, 5'd0);
    boundary(1, 1'b1, 5'b11111, F_11111, 1'b0, 5'd0);
    for (int m = 0; m < 32; m++)
      boundary(1, 1'b1, 5'(m), enc(5'(m)), 1'b0, 5'd0);
    boundary(1, 1'b0, 5'd0, 14'd0, 1'b0, 5'd0);

    // Another filler starts; abort it with reset partway through.
    chk("ready_before_abort_dut1", rdy[1], 1);
    push_frame(1, 14'd0, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    rst[1] = 1'b0;
    #1;
    chk("abort_valid_dut1", cv[1], 0);
    chk("abort_codebit_dut1", cb[1], 0);
    chk("abort_fs_dut1", fs[1], 0);
    chk("abort_uf_dut1", uf[1], 0);
    q1.delete();
    @(negedge clk);
    rst[1] = 1'b1;
    idle_check(1);
    idle_check(1);

    chk("queue_empty_dut0", q0.size(), 0);
    chk("queue_empty_dut1", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
